// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - two-requester add engine time-sharing one N-bit ripple adder over K chunks

// N-bit ripple-carry adder, port order (cout, sum, a, b, cin)
module adder_share_ripple #(
  parameter int N = 4
) (
  output logic         cout,
  output logic [N-1:0] sum,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin
);

  logic [N:0] carry_chain;

  assign carry_chain[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]           = a[i] ^ b[i] ^ carry_chain[i];
    assign carry_chain[i+1] = (a[i] & b[i]) | (carry_chain[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_chain[N];

endmodule

// Arbitrates two requesters round-robin and adds one N-bit chunk per cycle
module adder_share_ctrl #(
  parameter int N = 4,
  parameter int K = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid0,
  input  logic           in_valid1,
  output logic           in_ready0,
  output logic           in_ready1,
  input  logic [N*K-1:0] a0,
  input  logic [N*K-1:0] b0,
  input  logic [N*K-1:0] a1,
  input  logic [N*K-1:0] b1,
  input  logic           cin0,
  input  logic           cin1,
  output logic           res_valid,
  output logic           res_id,
  output logic [N*K-1:0] res_sum,
  output logic           res_cout
);

  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   acc;
  logic [W-1:0]   next_acc;
  logic           carry;
  logic [IW-1:0]  idx;
  logic           owner;
  logic           last_grant;

  logic           grant_any;
  logic           grant_id;

  logic [N-1:0]   add_a;
  logic [N-1:0]   add_b;
  logic           add_cin;
  logic [N-1:0]   add_sum;
  logic           add_cout;

  // Round-robin pick: on a tie the requester not served last wins; only offered in IDLE
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (!rst && state == IDLE) begin
      if (in_valid0 && in_valid1) begin
        grant_any = 1'b1;
        grant_id  = ~last_grant;
      end else if (in_valid0) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (in_valid1) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign in_ready0 = grant_any && !grant_id;
  assign in_ready1 = grant_any && grant_id;

  // Steer the current chunk into the shared adder during RUN; idle the adder otherwise
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      for (int c = 0; c < K; c++) begin
        if (idx == IW'(c)) begin
          add_a = op_a[c*N +: N];
          add_b = op_b[c*N +: N];
        end
      end
      add_cin = carry;
    end
  end

  // Partial result with the current chunk's sum merged in
  always_comb begin
    next_acc = acc;
    for (int c = 0; c < K; c++) begin
      if (idx == IW'(c)) begin
        next_acc[c*N +: N] = add_sum;
      end
    end
  end

  adder_share_ripple #(.N(N)) u_adder (
    .cout (add_cout),
    .sum  (add_sum),
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin)
  );

  // Control FSM: latch on grant, run K chunk cycles, publish the result in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a       <= grant_id ? a1 : a0;
            op_b       <= grant_id ? b1 : b0;
            carry      <= grant_id ? cin1 : cin0;
            owner      <= grant_id;
            last_grant <= grant_id;
            idx        <= '0;
            acc        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc   <= next_acc;
          carry <= add_cout;
          if (idx == IW'(K - 1)) begin
            idx       <= '0;
            res_valid <= 1'b1;
            res_sum   <= next_acc;
            res_cout  <= add_cout;
            res_id    <= owner;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          res_valid <= 1'b0;
          carry     <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb/tb_adder_share_ctrl.sv - randomized self-checking bench for adder_share_ctrl

module tb_adder_share_ctrl;

  localparam int N = 4;
  localparam int K = 2;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rst;
  logic         v [2];
  logic [W-1:0] a [2];
  logic [W-1:0] b [2];
  logic         ci [2];
  logic         rdy0, rdy1;
  logic         res_valid, res_id, res_cout;
  logic [W-1:0] res_sum;

  always #5 clk = ~clk;

  adder_share_ctrl #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid0 (v[0]),
    .in_valid1 (v[1]),
    .in_ready0 (rdy0),
    .in_ready1 (rdy1),
    .a0        (a[0]),
    .b0        (b[0]),
    .a1        (a[1]),
    .b1        (b[1]),
    .cin0      (ci[0]),
    .cin1      (ci[1]),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_cout  (res_cout)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: block is busy K+2 cycles per op, result is a+b+cin
  int           cyc = 0;
  int           free_at = 0;
  int           due = -1;
  int           last = 1;
  logic [W-1:0] hs = '0;
  logic         hc = 1'b0;
  logic         hid = 1'b0;
  logic [W-1:0] ps = '0;
  logic         pc = 1'b0;
  logic         pid = 1'b0;
  int           grants [2] = '{0, 0};
  bit           auto_mode [2] = '{0, 0};
  int           order [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic new_op(input int r);
    v[r]  = 1'b1;
    a[r]  = W'($urandom);
    b[r]  = W'($urandom);
    ci[r] = 1'($urandom_range(0, 1));
  endtask

  // one clock cycle: called just after a negedge with inputs already applied
  task automatic step();
    int         g;
    bit         xfer;
    logic [W:0] full;
    #1;
    xfer = 0;
    g    = 0;
    if (!rst && cyc >= free_at && (v[0] || v[1])) begin
      xfer = 1;
      if (v[0] && v[1]) g = (last == 0) ? 1 : 0;
      else              g = v[0] ? 0 : 1;
    end
    check("in_ready0", 32'(rdy0), 32'(xfer && g == 0));
    check("in_ready1", 32'(rdy1), 32'(xfer && g == 1));
    check("res_valid", 32'(res_valid), 32'(cyc == due));
    if (cyc == due) begin
      hs  = ps;
      hc  = pc;
      hid = pid;
    end
    check("res_sum", 32'(res_sum), 32'(hs));
    check("res_cout", 32'(res_cout), 32'(hc));
    check("res_id", 32'(res_id), 32'(hid));
    @(posedge clk);
    if (rst) begin
      free_at = cyc + 1;
      due     = -1;
      last    = 1;
      hs      = '0;
      hc      = 1'b0;
      hid     = 1'b0;
    end else if (xfer) begin
      last = g;
      grants[g]++;
      order.push_back(g);
      full = {1'b0, a[g]} + {1'b0, b[g]} + {{W{1'b0}}, ci[g]};
      ps   = full[W-1:0];
      pc   = full[W];
      pid  = 1'(g);
      due     = cyc + K + 1;
      free_at = cyc + K + 2;
    end
    @(negedge clk);
    if (!rst && xfer) begin
      if (auto_mode[g]) new_op(g);
      else              v[g] = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      v[r] = 1'b0; a[r] = '0; b[r] = '0; ci[r] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // carry ripples all the way out of bit W-1
    v[0] = 1'b1; a[0] = 8'hFF; b[0] = 8'h01; ci[0] = 1'b0;
    repeat (6) step();
    check("d0_sum", 32'(res_sum), 32'h00);
    check("d0_cout", 32'(res_cout), 32'h1);
    check("d0_id", 32'(res_id), 32'h0);

    // carry-in propagates across the chunk boundary
    v[1] = 1'b1; a[1] = 8'h0F; b[1] = 8'h00; ci[1] = 1'b1;
    repeat (6) step();
    check("d1_sum", 32'(res_sum), 32'h10);
    check("d1_cout", 32'(res_cout), 32'h0);
    check("d1_id", 32'(res_id), 32'h1);

    // both held after reset: strict alternation starting with requester 0
    do_reset();
    order.delete();
    auto_mode[0] = 1; auto_mode[1] = 1;
    new_op(0); new_op(1);
    repeat (24) step();
    check("alt_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++) check("alt_order", 32'(order[i]), 32'(i % 2));
    auto_mode[0] = 0; auto_mode[1] = 0;
    repeat (10) step();

    // requester 0 alone, held: one acceptance every K+2 cycles
    do_reset();
    grants[0] = 0; grants[1] = 0;
    auto_mode[0] = 1;
    new_op(0);
    repeat (40) step();
    check("solo_grants0", 32'(grants[0]), 32'd10);
    check("solo_grants1", 32'(grants[1]), 32'd0);
    auto_mode[0] = 0;
    repeat (6) step();

    // reset in the first RUN cycle drops the op; the next one completes normally
    new_op(0);
    step();
    do_reset();
    new_op(1);
    repeat (6) step();

    // random sweep
    grants[0] = 0; grants[1] = 0;
    for (int i = 0; i < 200; i++) begin
      for (int r = 0; r < 2; r++)
        if (!v[r] && $urandom_range(0, 2) == 0) new_op(r);
      step();
    end
    check("rand_ops", 32'(grants[0] + grants[1] >= 16), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
